// File: rtl/lsi_fifo_bridge.sv
// Bridge from ezusb_lsi register traffic to a pair of valid/ready word FIFOs plus status/control port.
// Optional LSI_FIFO_UC_EN: host-to-fabric bytes are folded ASCII lowercase -> uppercase before storage.
module lsi_fifo_bridge #(
  parameter int          DEPTH_LOG2  = 4,
  parameter logic [7:0]  DATA_ADDR   = 8'h00,
  parameter logic [7:0]  STATUS_ADDR = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        in_strobe,
  input  logic [7:0]  out_addr,
  input  logic        out_strobe,
  output logic [31:0] out_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [31:0]           h2f_mem [DEPTH];
  logic [31:0]           f2h_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] h2f_wr, h2f_rd, f2h_wr, f2h_rd;
  logic [DEPTH_LOG2:0]   h2f_level, f2h_level;
  logic                  ovf, udf;

  logic        wr_data, wr_ctl, rd_data, rd_stat;
  logic        h2f_full, f2h_empty;
  logic        h2f_push, h2f_pop, f2h_push, f2h_pop;
  logic        flush, clr, ovf_set, udf_set;
  logic [31:0] h2f_wdata;

  function automatic logic [31:0] to_upper(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (w[8*i +: 8] >= 8'd97 && w[8*i +: 8] <= 8'd122)
        r[8*i +: 8] = w[8*i +: 8] - 8'd32;
    end
    return r;
  endfunction

`ifdef LSI_FIFO_UC_EN
  assign h2f_wdata = to_upper(in_data);
`else
  assign h2f_wdata = in_data;
`endif

  assign wr_data   = in_strobe  && (in_addr  == DATA_ADDR);
  assign wr_ctl    = in_strobe  && (in_addr  == STATUS_ADDR);
  assign rd_data   = out_strobe && (out_addr == DATA_ADDR);
  assign rd_stat   = out_strobe && (out_addr == STATUS_ADDR);

  assign h2f_full  = (h2f_level == LVL_FULL);
  assign f2h_empty = (f2h_level == '0);

  // Handshake outputs depend only on registered levels and reset, never on the partner's strobe.
  assign rx_valid  = reset_n && (h2f_level != '0);
  assign tx_ready  = reset_n && (f2h_level != LVL_FULL);
  assign rx_data   = h2f_mem[h2f_rd];

  assign h2f_push  = wr_data && !h2f_full;
  assign h2f_pop   = rx_valid && rx_ready;
  assign f2h_push  = tx_valid && tx_ready;
  assign f2h_pop   = rd_data && !f2h_empty;

  assign flush     = wr_ctl && in_data[1];
  assign clr       = wr_ctl && in_data[0];
  assign ovf_set   = wr_data && h2f_full;
  assign udf_set   = rd_data && f2h_empty;

  // Storage is not reset; stale words are unreachable once pointers and levels are cleared.
  always_ff @(posedge clk) begin
    if (h2f_push && !flush) h2f_mem[h2f_wr] <= h2f_wdata;
    if (f2h_push && !flush) f2h_mem[f2h_wr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h2f_wr    <= '0;
      h2f_rd    <= '0;
      f2h_wr    <= '0;
      f2h_rd    <= '0;
      h2f_level <= '0;
      f2h_level <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        h2f_wr    <= '0;
        h2f_rd    <= '0;
        f2h_wr    <= '0;
        f2h_rd    <= '0;
        h2f_level <= '0;
        f2h_level <= '0;
      end else begin
        if (h2f_push) h2f_wr <= h2f_wr + PTR_ONE;
        if (h2f_pop)  h2f_rd <= h2f_rd + PTR_ONE;
        if (f2h_push) f2h_wr <= f2h_wr + PTR_ONE;
        if (f2h_pop)  f2h_rd <= f2h_rd + PTR_ONE;
        case ({h2f_push, h2f_pop})
          2'b10:   h2f_level <= h2f_level + LVL_ONE;
          2'b01:   h2f_level <= h2f_level - LVL_ONE;
          default: h2f_level <= h2f_level;
        endcase
        case ({f2h_push, f2h_pop})
          2'b10:   f2h_level <= f2h_level + LVL_ONE;
          2'b01:   f2h_level <= f2h_level - LVL_ONE;
          default: f2h_level <= f2h_level;
        endcase
      end

      ovf <= ovf_set | (ovf & ~clr);
      udf <= udf_set | (udf & ~clr);

      // A data read in a flush cycle still returns the pre-flush head.
      if (rd_data)
        out_data <= f2h_empty ? 32'h0 : f2h_mem[f2h_rd];
      else if (rd_stat)
        out_data <= {8'(h2f_level), 8'(f2h_level), 14'h0, udf, ovf};
      else if (out_strobe)
        out_data <= 32'h0;
    end
  end

endmodule

// File: tb/tb_lsi_fifo_bridge.sv
// Directed bench for lsi_fifo_bridge: vector table for host port traffic plus corner-case sequences.
module tb_lsi_fifo_bridge;

  localparam logic [7:0] DA = 8'h00;
  localparam logic [7:0] SA = 8'h01;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_addr, out_addr;
  logic [31:0] in_data, out_data, rx_data, tx_data;
  logic        in_strobe, out_strobe, rx_valid, rx_ready, tx_valid, tx_ready;

  int checks = 0;
  int failures = 0;

  lsi_fifo_bridge #(.DEPTH_LOG2(4), .DATA_ADDR(DA), .STATUS_ADDR(SA)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_addr(in_addr), .in_data(in_data), .in_strobe(in_strobe),
    .out_addr(out_addr), .out_strobe(out_strobe), .out_data(out_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] q[$];
  logic [31:0] rd_val, exp_val;
  logic        do_push, do_rd, can_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // All host tasks start and end just after a falling edge.
  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    in_addr = a; in_data = d; in_strobe = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [31:0] v);
    out_addr = a; out_strobe = 1'b1;
    @(negedge clk);
    out_strobe = 1'b0;
    v = out_data;
  endtask

  task automatic fab_push(input logic [31:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, DA,    32'h0, 32'hA0A0_0001};
    vecs[1]  = '{1'b0, DA,    32'h0, 32'hB0B0_0002};
    vecs[2]  = '{1'b0, DA,    32'h0, 32'hC0C0_0003};
    vecs[3]  = '{1'b0, DA,    32'h0, 32'h0000_0000};
    vecs[4]  = '{1'b0, SA,    32'h0, 32'h0000_0002};
    vecs[5]  = '{1'b0, 8'h05, 32'h0, 32'h0000_0000};
    vecs[6]  = '{1'b1, 8'h07, 32'h3, 32'h0};
    vecs[7]  = '{1'b0, SA,    32'h0, 32'h0000_0002};
    vecs[8]  = '{1'b1, SA,    32'h1, 32'h0};
    vecs[9]  = '{1'b0, SA,    32'h0, 32'h0000_0000};
    vecs[10] = '{1'b1, DA,    32'h1122_3344, 32'h0};
    vecs[11] = '{1'b0, SA,    32'h0, 32'h0100_0000};
    vecs[12] = '{1'b0, DA,    32'h0, 32'h0000_0000};
    vecs[13] = '{1'b0, SA,    32'h0, 32'h0100_0002};
    vecs[14] = '{1'b1, SA,    32'h3, 32'h0};
    vecs[15] = '{1'b0, SA,    32'h0, 32'h0000_0000};

    reset_n = 1'b0; in_addr = '0; in_data = '0; in_strobe = 1'b0;
    out_addr = '0; out_strobe = 1'b0; rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    reset_n = 1'b1;
    #1 chk("rel_tx_ready", {31'h0, tx_ready}, 32'h1);
    @(negedge clk);

    // Single word through H2F with the fabric always ready.
    rx_ready = 1'b1;
    host_wr(DA, 32'h6463_6261);
    chk("h2f_beat_valid", {31'h0, rx_valid}, 32'h1);
`ifdef LSI_FIFO_UC_EN
    chk("h2f_beat_data", rx_data, 32'h4443_4241);
`else
    chk("h2f_beat_data", rx_data, 32'h6463_6261);
`endif
    @(negedge clk);
    chk("h2f_one_beat", {31'h0, rx_valid}, 32'h0);
    host_rd(SA, rd_val);
    chk("stat_after_beat", rd_val, 32'h0);

    // Overflow: 17 writes into a 16-deep FIFO.
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) host_wr(DA, 32'(i + 1));
    host_rd(SA, rd_val);
    chk("ovf_status", rd_val, 32'h1000_0001);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_valid[%0d]", i), {31'h0, rx_valid}, 32'h1);
      chk($sformatf("drain_data[%0d]", i), rx_data, 32'(i + 1));
      @(negedge clk);
    end
    chk("drain_empty", {31'h0, rx_valid}, 32'h0);
    rx_ready = 1'b0;
    host_rd(SA, rd_val);
    chk("ovf_sticky", rd_val, 32'h0000_0001);
    host_wr(SA, 32'h1);
    host_rd(SA, rd_val);
    chk("ovf_cleared", rd_val, 32'h0);

    // F2H A/B/C, underflow, other addresses, flag clear; driven from the vector table.
    fab_push(32'hA0A0_0001);
    fab_push(32'hB0B0_0002);
    fab_push(32'hC0C0_0003);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) host_wr(vecs[i].addr, vecs[i].data);
      else begin
        host_rd(vecs[i].addr, rd_val);
        chk($sformatf("vec[%0d]", i), rd_val, vecs[i].exp);
      end
    end

    // Fill F2H to 15, then simultaneous push/pop and 40 mixed cycles against a queue model.
    q.delete();
    for (int i = 0; i < 15; i++) begin
      fab_push(32'h100 + 32'(i));
      q.push_back(32'h100 + 32'(i));
    end
    host_rd(SA, rd_val);
    chk("f2h_level15", rd_val, 32'h000F_0000);
    for (int i = -1; i < 40; i++) begin
      do_push = (i < 0) ? 1'b1 : ((i % 3) != 2);
      do_rd   = (i < 0) ? 1'b1 : ((i % 2) == 0);
      can_push = (q.size() < 16);
      chk($sformatf("mix_tx_ready[%0d]", i), {31'h0, tx_ready}, {31'h0, can_push});
      exp_val = 32'h0;
      if (do_rd && q.size() > 0) exp_val = q.pop_front();
      if (do_push && can_push) q.push_back(32'h200 + 32'(i + 1));
      tx_data = 32'h200 + 32'(i + 1); tx_valid = do_push;
      out_addr = DA; out_strobe = do_rd;
      @(negedge clk);
      tx_valid = 1'b0; out_strobe = 1'b0;
      if (do_rd) chk($sformatf("mix_rd[%0d]", i), out_data, exp_val);
      if (i < 0) begin
        host_rd(SA, rd_val);
        chk("pushpop_level15", rd_val, 32'h000F_0000);
      end
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      exp_val = q.pop_front();
      host_rd(DA, rd_val);
      chk($sformatf("mix_drain[%0d]", i), rd_val, exp_val);
    end
    host_rd(SA, rd_val);
    chk("mix_final_status", rd_val, 32'h0);

    // Flush alongside an F2H push and an F2H data read.
    host_wr(DA, 32'h0000_0A01);
    host_wr(DA, 32'h0000_0A02);
    fab_push(32'h0000_0B01);
    fab_push(32'h0000_0B02);
    host_rd(SA, rd_val);
    chk("pre_flush_status", rd_val, 32'h0202_0000);
    in_addr = SA; in_data = 32'h2; in_strobe = 1'b1;
    out_addr = DA; out_strobe = 1'b1;
    tx_data = 32'h0000_0B03; tx_valid = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0; out_strobe = 1'b0; tx_valid = 1'b0;
    chk("flush_read_head", out_data, 32'h0000_0B01);
    chk("flush_rx_valid", {31'h0, rx_valid}, 32'h0);
    host_rd(SA, rd_val);
    chk("flush_status", rd_val, 32'h0);
    host_rd(DA, rd_val);
    chk("flush_f2h_gone", rd_val, 32'h0);
    host_wr(SA, 32'h1);
    host_wr(DA, 32'h0000_0A09);
    chk("post_flush_head", rx_data, 32'h0000_0A09);

    // One-cycle reset mid-stream.
    fab_push(32'h0000_0C01);
    host_rd(SA, rd_val);
    chk("pre_reset_status", rd_val, 32'h0101_0000);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("mid_rst_tx_ready", {31'h0, tx_ready}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_out_data", out_data, 32'h0);
    chk("post_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    chk("post_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    @(negedge clk);
    chk("post_rst_no_stale", {31'h0, rx_valid}, 32'h0);
    host_rd(SA, rd_val);
    chk("post_rst_status", rd_val, 32'h0);
    host_rd(DA, rd_val);
    chk("post_rst_f2h_empty", rd_val, 32'h0);
    host_rd(SA, rd_val);
    chk("post_rst_udf", rd_val, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
